am2909: RTL and testbench

- Bit-slice microprogram sequencer (Am2909 behaviour), parameterised width.
- Selects the next microaddress from four sources: uPC, address register AR, stack top STK0, or direct input D.
- Selected address is OR-masked and zero-forced, then driven tri-state on Y.
- Contains an incrementer feeding uPC and a 4-deep wrap-around push/pop stack; slices cascade via cn/cn4.

---
 rtl/am2909_pkg.sv | 19 +
 rtl/am2909_if.sv | 42 ++++
 rtl/am2909_stack.sv | 81 ++++++++
 rtl/am2909.sv | 72 +++++++
 tb/tb_am2909.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/am2909_pkg.sv
// Shared definitions for the Am2909 microprogram sequencer slice.
// Source-select encodings and stack geometry used by the top and the stack.
package am2909_pkg;

    typedef enum logic [1:0] {
        SRC_UPC = 2'b00,
        SRC_AR  = 2'b01,
        SRC_STK = 2'b10,
        SRC_D   = 2'b11
    } src_sel_t;

    localparam int unsigned STACK_DEPTH = 4;
    localparam int unsigned SP_W        = 2;
    localparam int unsigned DEPTH_W     = 3;

    typedef logic [SP_W-1:0]    sp_t;
    typedef logic [DEPTH_W-1:0] depth_t;

endpackage

// File: rtl/am2909_if.sv
// Control/data bus of one Am2909 slice (everything except clock, reset and tri-state y).
// Optional stack flags appear when AM2909_STACK_FLAGS_EN is defined.
interface am2909_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rin;
    logic [WIDTH-1:0] orin;
    logic             cn;
    logic             oe_;
    logic             zero_;
    logic             re_;
    logic             fe_;
    logic             pup;
    logic [1:0]       s;
    logic             cn4;
`ifdef AM2909_STACK_FLAGS_EN
    logic             stk_empty;
    logic             stk_full;

    modport master (
        output din, rin, orin, cn, oe_, zero_, re_, fe_, pup, s,
        input  cn4, stk_empty, stk_full
    );

    modport slave (
        input  din, rin, orin, cn, oe_, zero_, re_, fe_, pup, s,
        output cn4, stk_empty, stk_full
    );
`else
    modport master (
        output din, rin, orin, cn, oe_, zero_, re_, fe_, pup, s,
        input  cn4
    );

    modport slave (
        input  din, rin, orin, cn, oe_, zero_, re_, fe_, pup, s,
        output cn4
    );
`endif

endinterface

// File: rtl/am2909_stack.sv
// Four-entry wrap-around push/pop stack of the Am2909; top of stack is entry[sp].
// With AM2909_STACK_FLAGS_EN a saturating 0..4 depth counter drives empty/full flags.
module am2909_stack
    import am2909_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             cp,
    input  logic             reset,
    input  logic             fe_,
    input  logic             pup,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] stk0
`ifdef AM2909_STACK_FLAGS_EN
    ,
    output logic             stk_empty,
    output logic             stk_full
`endif
);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [WIDTH-1:0] mem_d [STACK_DEPTH];
    sp_t              sp_q;
    sp_t              sp_d;
    sp_t              sp_inc;
    sp_t              sp_dec;

    assign sp_inc = sp_q + 1'b1;
    assign sp_dec = sp_q - 1'b1;
    assign stk0   = mem_q[sp_q];

    // Push writes the slot above the current top; the pointer wraps, so a fifth push overwrites the oldest.
    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (!fe_) begin
            if (pup) begin
                sp_d         = sp_inc;
                mem_d[sp_inc] = push_data;
            end else begin
                sp_d = sp_dec;
            end
        end
    end

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            sp_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

`ifdef AM2909_STACK_FLAGS_EN
    depth_t depth_q;
    depth_t depth_d;

    // Depth only tracks occupancy; data movement above still wraps freely.
    always_comb begin
        depth_d = depth_q;
        if (!fe_) begin
            if (pup) begin
                if (depth_q != DEPTH_W'(STACK_DEPTH)) depth_d = depth_q + 1'b1;
            end else begin
                if (depth_q != '0) depth_d = depth_q - 1'b1;
            end
        end
    end

    always_ff @(posedge cp or posedge reset) begin
        if (reset) depth_q <= '0;
        else       depth_q <= depth_d;
    end

    assign stk_empty = (depth_q == '0);
    assign stk_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
`endif

endmodule

// File: rtl/am2909.sv
// Am2909 bit-slice microprogram sequencer: source mux, OR/zero masking, incrementer, uPC, AR, stack.
// Define AM2909_STACK_FLAGS_EN to expose stk_empty/stk_full on the bus interface.
module am2909
    import am2909_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             cp,
    input  logic             reset,
    am2909_if.slave          bus,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] upc_q;
    logic [WIDTH-1:0] upc_d;
    logic [WIDTH-1:0] ar_q;
    logic [WIDTH-1:0] ar_d;
    logic [WIDTH-1:0] stk0;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] inc;
    logic             carry;

    always_comb begin
        src = upc_q;
        case (src_sel_t'(bus.s))
            SRC_UPC: src = upc_q;
            SRC_AR:  src = ar_q;
            SRC_STK: src = stk0;
            SRC_D:   src = bus.din;
            default: src = upc_q;
        endcase
    end

    // The incrementer sees the internal address even while y is tri-stated.
    always_comb begin
        addr         = bus.zero_ ? (src | bus.orin) : '0;
        {carry, inc} = {1'b0, addr} + {{WIDTH{1'b0}}, bus.cn};
        upc_d        = inc;
        ar_d         = bus.re_ ? ar_q : bus.rin;
    end

    always_ff @(posedge cp or posedge reset) begin
        if (reset) begin
            upc_q <= '0;
            ar_q  <= '0;
        end else begin
            upc_q <= upc_d;
            ar_q  <= ar_d;
        end
    end

    assign bus.cn4 = carry;
    assign y       = bus.oe_ ? 'z : addr;

    am2909_stack #(
        .WIDTH (WIDTH)
    ) u_stack (
        .cp        (cp),
        .reset     (reset),
        .fe_       (bus.fe_),
        .pup       (bus.pup),
        .push_data (upc_q),
        .stk0      (stk0)
`ifdef AM2909_STACK_FLAGS_EN
        ,
        .stk_empty (bus.stk_empty),
        .stk_full  (bus.stk_full)
`endif
    );

endmodule

// File: tb/tb_am2909.sv
// Directed self-checking bench for the Am2909 sequencer slice (WIDTH=4).
// Flag checks compile in only when AM2909_STACK_FLAGS_EN is defined.
module tb_am2909;

    logic      cp;
    logic      reset;
    wire [3:0] y;
    int        n_checks;
    int        n_fail;

    am2909_if #(.WIDTH(4)) bus ();

    am2909 #(.WIDTH(4)) dut (
        .cp    (cp),
        .reset (reset),
        .bus   (bus),
        .y     (y)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL reset_y: got %b expected %b", y, 4'b0000);
        end
        n_checks++;
        if (bus.cn4 !== 1'b0) begin
            n_fail++; $display("FAIL reset_cn4: got %b expected %b", bus.cn4, 1'b0);
        end
`ifdef AM2909_STACK_FLAGS_EN
        n_checks++;
        if (bus.stk_empty !== 1'b1 || bus.stk_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got e=%b f=%b expected e=1 f=0", bus.stk_empty, bus.stk_full);
        end
`endif
    endtask

    task automatic test_output_control();
        bus.oe_ = 1'b1; bus.s = 2'b11; bus.din = 4'b1111; bus.orin = 4'b0000; bus.cn = 1'b1;
        #1;
        n_checks++;
        if (y === 4'b1111) begin
            n_fail++; $display("FAIL oe_hiz: got %b expected high-Z", y);
        end
        n_checks++;
        if (bus.cn4 !== 1'b1) begin
            n_fail++; $display("FAIL cn4_while_hiz: got %b expected %b", bus.cn4, 1'b1);
        end
        bus.cn = 1'b0; bus.oe_ = 1'b0; bus.zero_ = 1'b0;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL zero_force: got %b expected %b", y, 4'b0000);
        end
        bus.zero_ = 1'b1; bus.din = 4'b0000; bus.orin = 4'b1111;
        #1;
        n_checks++;
        if (y !== 4'b1111) begin
            n_fail++; $display("FAIL or_mask: got %b expected %b", y, 4'b1111);
        end
        bus.din = 4'b0101; bus.orin = 4'b0000;
        #1;
        n_checks++;
        if (y !== 4'b0101) begin
            n_fail++; $display("FAIL din_pass: got %b expected %b", y, 4'b0101);
        end
    endtask

    task automatic test_ar_upc();
        step();
        bus.re_ = 1'b0; bus.rin = 4'b1010; bus.s = 2'b01; bus.cn = 1'b0;
        step();
        bus.re_ = 1'b1; bus.rin = 4'b0101;
        #1;
        n_checks++;
        if (y !== 4'b1010) begin
            n_fail++; $display("FAIL ar_load: got %b expected %b", y, 4'b1010);
        end
        step();
        n_checks++;
        if (y !== 4'b1010) begin
            n_fail++; $display("FAIL ar_hold: got %b expected %b", y, 4'b1010);
        end
        bus.zero_ = 1'b0;
        step();
        bus.zero_ = 1'b1; bus.s = 2'b00;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL upc_clear: got %b expected %b", y, 4'b0000);
        end
        bus.cn = 1'b1;
        step();
        n_checks++;
        if (y !== 4'b0001) begin
            n_fail++; $display("FAIL upc_inc1: got %b expected %b", y, 4'b0001);
        end
        step();
        n_checks++;
        if (y !== 4'b0010) begin
            n_fail++; $display("FAIL upc_inc2: got %b expected %b", y, 4'b0010);
        end
        n_checks++;
        if (bus.cn4 !== 1'b0) begin
            n_fail++; $display("FAIL cn4_low: got %b expected %b", bus.cn4, 1'b0);
        end
        bus.s = 2'b11; bus.din = 4'b1111;
        #1;
        n_checks++;
        if (bus.cn4 !== 1'b1) begin
            n_fail++; $display("FAIL cn4_high: got %b expected %b", bus.cn4, 1'b1);
        end
        step();
        bus.s = 2'b00; bus.cn = 1'b0;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL upc_wrap: got %b expected %b", y, 4'b0000);
        end
    endtask

    task automatic test_stack_fill();
        logic [3:0] exp;
        bus.s = 2'b11; bus.din = 4'b0010; bus.cn = 1'b0;
        step();
        bus.s = 2'b00; bus.cn = 1'b1; bus.fe_ = 1'b0; bus.pup = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            exp = 4'(3 + i);
            n_checks++;
            if (y !== exp) begin
                n_fail++; $display("FAIL push_upc[%0d]: got %b expected %b", i, y, exp);
            end
        end
        bus.fe_ = 1'b1; bus.s = 2'b10; bus.cn = 1'b0;
        #1;
        n_checks++;
        if (y !== 4'b0101) begin
            n_fail++; $display("FAIL stack_top_after_fill: got %b expected %b", y, 4'b0101);
        end
`ifdef AM2909_STACK_FLAGS_EN
        n_checks++;
        if (bus.stk_full !== 1'b1 || bus.stk_empty !== 1'b0) begin
            n_fail++; $display("FAIL flags_full: got e=%b f=%b expected e=0 f=1", bus.stk_empty, bus.stk_full);
        end
`endif
        bus.fe_ = 1'b0; bus.pup = 1'b0;
        step();
        bus.fe_ = 1'b1;
        #1;
        n_checks++;
        if (y !== 4'b0100) begin
            n_fail++; $display("FAIL pop_top: got %b expected %b", y, 4'b0100);
        end
`ifdef AM2909_STACK_FLAGS_EN
        n_checks++;
        if (bus.stk_full !== 1'b0) begin
            n_fail++; $display("FAIL flags_not_full: got %b expected %b", bus.stk_full, 1'b0);
        end
`endif
    endtask

    task automatic test_subroutine();
        bus.s = 2'b11; bus.din = 4'b1011; bus.cn = 1'b0; bus.fe_ = 1'b1;
        step();
        bus.fe_ = 1'b0; bus.pup = 1'b1;
        step();
        bus.fe_ = 1'b1; bus.s = 2'b10;
        #1;
        n_checks++;
        if (y !== 4'b1011) begin
            n_fail++; $display("FAIL sub_setup_top: got %b expected %b", y, 4'b1011);
        end
        bus.fe_ = 1'b0; bus.pup = 1'b0; bus.cn = 1'b1;
        step();
        n_checks++;
        if (y !== 4'b0100) begin
            n_fail++; $display("FAIL loop_pop: got %b expected %b", y, 4'b0100);
        end
        bus.pup = 1'b1;
        step();
        bus.fe_ = 1'b1;
        #1;
        n_checks++;
        if (y !== 4'b1100) begin
            n_fail++; $display("FAIL call_push_top: got %b expected %b", y, 4'b1100);
        end
        bus.s = 2'b00;
        #1;
        n_checks++;
        if (y !== 4'b0101) begin
            n_fail++; $display("FAIL call_upc: got %b expected %b", y, 4'b0101);
        end
        bus.s = 2'b11; bus.din = 4'b1110; bus.fe_ = 1'b0; bus.pup = 1'b0;
        #1;
        n_checks++;
        if (y !== 4'b1110) begin
            n_fail++; $display("FAIL return_din: got %b expected %b", y, 4'b1110);
        end
        step();
        bus.fe_ = 1'b1; bus.s = 2'b00;
        #1;
        n_checks++;
        if (y !== 4'b1111) begin
            n_fail++; $display("FAIL return_upc: got %b expected %b", y, 4'b1111);
        end
        bus.s = 2'b10;
        #1;
        n_checks++;
        if (y !== 4'b0100) begin
            n_fail++; $display("FAIL return_top: got %b expected %b", y, 4'b0100);
        end
    endtask

    task automatic test_pop_wrap();
        logic [3:0] exp_top [4];
        exp_top[0] = 4'b0011; exp_top[1] = 4'b0010; exp_top[2] = 4'b1100; exp_top[3] = 4'b0100;
        bus.fe_ = 1'b0; bus.pup = 1'b0; bus.s = 2'b10; bus.cn = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (y !== exp_top[i]) begin
                n_fail++; $display("FAIL pop_wrap[%0d]: got %b expected %b", i, y, exp_top[i]);
            end
`ifdef AM2909_STACK_FLAGS_EN
            if (i >= 2) begin
                n_checks++;
                if (bus.stk_empty !== 1'b1) begin
                    n_fail++; $display("FAIL flags_empty[%0d]: got %b expected %b", i, bus.stk_empty, 1'b1);
                end
            end
`endif
        end
        bus.fe_ = 1'b1;
    endtask

    task automatic test_async_reset();
        bus.fe_ = 1'b0; bus.pup = 1'b1; bus.s = 2'b00; bus.cn = 1'b1;
        step();
        bus.fe_ = 1'b1; bus.re_ = 1'b0; bus.rin = 4'b1010;
        step();
        bus.re_ = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL areset_upc: got %b expected %b", y, 4'b0000);
        end
        bus.s = 2'b01;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL areset_ar: got %b expected %b", y, 4'b0000);
        end
        bus.s = 2'b10;
        #1;
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL areset_stack: got %b expected %b", y, 4'b0000);
        end
`ifdef AM2909_STACK_FLAGS_EN
        n_checks++;
        if (bus.stk_empty !== 1'b1) begin
            n_fail++; $display("FAIL areset_flags: got %b expected %b", bus.stk_empty, 1'b1);
        end
`endif
        reset = 1'b0; bus.s = 2'b00; bus.cn = 1'b0;
        step();
        n_checks++;
        if (y !== 4'b0000) begin
            n_fail++; $display("FAIL post_reset_hold: got %b expected %b", y, 4'b0000);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.din  = '0; bus.rin = '0; bus.orin = '0;
        bus.cn   = 1'b0; bus.oe_ = 1'b0; bus.zero_ = 1'b1;
        bus.re_  = 1'b1; bus.fe_ = 1'b1; bus.pup = 1'b0; bus.s = 2'b00;
        #12;
        reset = 1'b0;
        step();
        test_reset();
        test_output_control();
        test_ar_upc();
        test_stack_fill();
        test_subroutine();
        test_pop_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
